dds_rom_sched: RTL and testbench

- Two-channel DDS sequencer that time-multiplexes one synchronous sine-wave ROM port (single-port ROM IP, read-only, 1 or 2 cycle read latency).
- Holds a phase accumulator per channel, issues ROM addresses on alternating cycles and steers returned ROM data to the owning channel with a valid strobe.
- Sits between the LA/test-signal control registers and the DAC/probe-generator datapath.

---
 rtl/dds_rom_sched.sv | 144 ++++++++++++++
 tb/tb_dds_rom_sched.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_rom_sched.sv
// Two-channel DDS sequencer time-multiplexing one synchronous sine ROM port.
// Optional: define DDS_AMP_SCALE_EN for per-channel 8-bit amplitude scaling (one extra pipe stage).
module dds_rom_sched #(
    parameter int PHASE_W = 32,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 8,
    parameter int ROM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               sync,
    input  logic [PHASE_W-1:0] ch0_fword,
    input  logic [PHASE_W-1:0] ch1_fword,
    input  logic [ADDR_W-1:0]  ch0_poff,
    input  logic [ADDR_W-1:0]  ch1_poff,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [DATA_W-1:0]  rom_data,
`ifdef DDS_AMP_SCALE_EN
    input  logic [7:0]         ch0_amp,
    input  logic [7:0]         ch1_amp,
`endif
    output logic [DATA_W-1:0]  ch0_data,
    output logic               ch0_valid,
    output logic [DATA_W-1:0]  ch1_data,
    output logic               ch1_valid
);

    logic               slot_q, slot_d;
    logic [PHASE_W-1:0] acc0_q, acc0_d, acc1_q, acc1_d;
    logic [ADDR_W-1:0]  romAddr_q, romAddr_d;
    logic [ROM_LAT:0]   tagValid_q, tagValid_d;
    logic [ROM_LAT:0]   tagCh_q, tagCh_d;
    logic [DATA_W-1:0]  ch0Data_q, ch0Data_d, ch1Data_q, ch1Data_d;
    logic               ch0Valid_q, ch0Valid_d, ch1Valid_q, ch1Valid_d;
    logic               issue, retValid, retCh;
    logic               outValid, outCh;
    logic [DATA_W-1:0]  outData;

    // Issue side: the slot owner reads its accumulator, then advances it.
    // Stage k of the tag pipe describes the read issued k cycles ago.
    always_comb begin
        issue     = en && !sync;
        slot_d    = slot_q;
        acc0_d    = acc0_q;
        acc1_d    = acc1_q;
        romAddr_d = romAddr_q;
        if (sync) begin
            slot_d = 1'b0;
            acc0_d = '0;
            acc1_d = '0;
        end else if (en) begin
            slot_d = ~slot_q;
            if (slot_q) begin
                romAddr_d = acc1_q[PHASE_W-1 -: ADDR_W] + ch1_poff;
                acc1_d    = acc1_q + ch1_fword;
            end else begin
                romAddr_d = acc0_q[PHASE_W-1 -: ADDR_W] + ch0_poff;
                acc0_d    = acc0_q + ch0_fword;
            end
        end
        tagValid_d = sync ? '0 : {tagValid_q[ROM_LAT-1:0], issue};
        tagCh_d    = {tagCh_q[ROM_LAT-1:0], slot_q};
        retValid   = tagValid_q[ROM_LAT] && !sync;
        retCh      = tagCh_q[ROM_LAT];
    end

`ifdef DDS_AMP_SCALE_EN
    logic              stgValid_q, stgValid_d, stgCh_q, stgCh_d;
    logic [DATA_W-1:0] stgData_q, stgData_d;
    logic [7:0]        ampSel;

    always_comb begin
        ampSel     = retCh ? ch1_amp : ch0_amp;
        stgValid_d = retValid;
        stgCh_d    = retCh;
        stgData_d  = stgData_q;
        if (retValid) begin
            stgData_d = DATA_W'(({8'd0, rom_data} * {{DATA_W{1'b0}}, ampSel}) >> 8);
        end
        outValid = stgValid_q && !sync;
        outCh    = stgCh_q;
        outData  = stgData_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stgValid_q <= 1'b0;
            stgCh_q    <= 1'b0;
            stgData_q  <= '0;
        end else begin
            stgValid_q <= stgValid_d;
            stgCh_q    <= stgCh_d;
            stgData_q  <= stgData_d;
        end
    end
`else
    always_comb begin
        outValid = retValid;
        outCh    = retCh;
        outData  = rom_data;
    end
`endif

    always_comb begin
        ch0Valid_d = outValid && !outCh;
        ch1Valid_d = outValid && outCh;
        ch0Data_d  = ch0Valid_d ? outData : ch0Data_q;
        ch1Data_d  = ch1Valid_d ? outData : ch1Data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q     <= 1'b0;
            acc0_q     <= '0;
            acc1_q     <= '0;
            romAddr_q  <= '0;
            tagValid_q <= '0;
            tagCh_q    <= '0;
            ch0Data_q  <= '0;
            ch1Data_q  <= '0;
            ch0Valid_q <= 1'b0;
            ch1Valid_q <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            acc0_q     <= acc0_d;
            acc1_q     <= acc1_d;
            romAddr_q  <= romAddr_d;
            tagValid_q <= tagValid_d;
            tagCh_q    <= tagCh_d;
            ch0Data_q  <= ch0Data_d;
            ch1Data_q  <= ch1Data_d;
            ch0Valid_q <= ch0Valid_d;
            ch1Valid_q <= ch1Valid_d;
        end
    end

    assign rom_addr  = romAddr_q;
    assign ch0_data  = ch0Data_q;
    assign ch0_valid = ch0Valid_q;
    assign ch1_data  = ch1Data_q;
    assign ch1_valid = ch1Valid_q;

endmodule

// File: tb/tb_dds_rom_sched.sv
// Self-checking bench for dds_rom_sched: one instance with ROM_LAT=1 and one with ROM_LAT=2,
// both compared every cycle against a behavioural schedule model.
module tb_dds_rom_sched;

    localparam int PW   = 32;
    localparam int AW   = 10;
    localparam int DW   = 8;
    localparam int MAXC = 4096;
`ifdef DDS_AMP_SCALE_EN
    localparam int AMPX = 1;
`else
    localparam int AMPX = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n, en, sync;
    logic [PW-1:0] fw0, fw1;
    logic [AW-1:0] poff0, poff1;
    logic [7:0]    amp0, amp1;

    logic [AW-1:0] romAddrA, romAddrB;
    logic [DW-1:0] romDataA, romDataB, romPipeB;
    logic [DW-1:0] ch0DataA, ch1DataA, ch0DataB, ch1DataB;
    logic          ch0ValidA, ch1ValidA, ch0ValidB, ch1ValidB;

    always #5 clk = ~clk;

    dds_rom_sched #(.PHASE_W(PW), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1)) dutA (
        .clk(clk), .rst_n(rst_n), .en(en), .sync(sync),
        .ch0_fword(fw0), .ch1_fword(fw1), .ch0_poff(poff0), .ch1_poff(poff1),
        .rom_addr(romAddrA), .rom_data(romDataA),
`ifdef DDS_AMP_SCALE_EN
        .ch0_amp(amp0), .ch1_amp(amp1),
`endif
        .ch0_data(ch0DataA), .ch0_valid(ch0ValidA),
        .ch1_data(ch1DataA), .ch1_valid(ch1ValidA)
    );

    dds_rom_sched #(.PHASE_W(PW), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(2)) dutB (
        .clk(clk), .rst_n(rst_n), .en(en), .sync(sync),
        .ch0_fword(fw0), .ch1_fword(fw1), .ch0_poff(poff0), .ch1_poff(poff1),
        .rom_addr(romAddrB), .rom_data(romDataB),
`ifdef DDS_AMP_SCALE_EN
        .ch0_amp(amp0), .ch1_amp(amp1),
`endif
        .ch0_data(ch0DataB), .ch0_valid(ch0ValidB),
        .ch1_data(ch1DataB), .ch1_valid(ch1ValidB)
    );

    // ROM contents are simply the low byte of the address; one or two read stages.
    initial begin
        romDataA = '0;
        romDataB = '0;
        romPipeB = '0;
    end
    always @(posedge clk) begin
        romDataA <= romAddrA[7:0];
        romPipeB <= romAddrB[7:0];
        romDataB <= romPipeB;
    end

    int checks = 0;
    int errors = 0;
    int edgeN  = 0;
    int lat [2] = '{1, 2};

    // Reference model: per-channel phase, which channel owns the next issue, and a
    // per-edge schedule of expected strobes with their data.
    logic [PW-1:0] mAcc [2];
    int            mSlot;
    logic [AW-1:0] mAddr;
    bit            expV [2][2][MAXC];
    logic [7:0]    expD [2][2][MAXC];
    logic [7:0]    mHeld [2][2];

    function automatic logic [7:0] scale(input logic [7:0] d, input logic [7:0] a);
`ifdef DDS_AMP_SCALE_EN
        logic [15:0] p;
        p = 16'(d) * 16'(a);
        return p[15:8];
`else
        if (a == 8'hxx) return 8'h00;
        return d;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s edge=%0d observed=%0h expected=%0h", tag, edgeN, obs, exp);
        end
    endtask

    task automatic modelReset();
        mAcc[0] = '0;
        mAcc[1] = '0;
        mSlot   = 0;
        mAddr   = '0;
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 2; c++) begin
                mHeld[d][c] = '0;
                for (int e = edgeN + 1; e < edgeN + 6 && e < MAXC; e++) expV[d][c][e] = 1'b0;
            end
    endtask

    // One clock edge as seen by the model, using the inputs that were present at it.
    task automatic modelEdge();
        logic [AW-1:0] a;
        logic [PW-1:0] scaled;
        int            e;
        if (sync) begin
            mAcc[0] = '0;
            mAcc[1] = '0;
            mSlot   = 0;
            for (int d = 0; d < 2; d++)
                for (int c = 0; c < 2; c++)
                    for (int k = edgeN; k < edgeN + 5 && k < MAXC; k++) expV[d][c][k] = 1'b0;
        end else if (en) begin
            scaled = mAcc[mSlot] >> (PW - AW);
            a      = AW'(scaled) + ((mSlot == 1) ? poff1 : poff0);
            mAddr  = a;
            mAcc[mSlot] = mAcc[mSlot] + ((mSlot == 1) ? fw1 : fw0);
            for (int d = 0; d < 2; d++) begin
                e = edgeN + lat[d] + 1 + AMPX;
                if (e < MAXC) begin
                    expV[d][mSlot][e] = 1'b1;
                    expD[d][mSlot][e] = scale(a[7:0], (mSlot == 1) ? amp1 : amp0);
                end
            end
            mSlot = 1 - mSlot;
        end
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 2; c++)
                if (edgeN < MAXC && expV[d][c][edgeN]) mHeld[d][c] = expD[d][c][edgeN];
    endtask

    task automatic checkOutput();
        bit v [2][2];
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 2; c++)
                v[d][c] = rst_n && edgeN < MAXC && expV[d][c][edgeN];
        check("addrA",  64'(romAddrA),  64'(mAddr));
        check("addrB",  64'(romAddrB),  64'(mAddr));
        check("ch0vA",  64'(ch0ValidA), 64'(v[0][0]));
        check("ch1vA",  64'(ch1ValidA), 64'(v[0][1]));
        check("ch0dA",  64'(ch0DataA),  64'(mHeld[0][0]));
        check("ch1dA",  64'(ch1DataA),  64'(mHeld[0][1]));
        check("ch0vB",  64'(ch0ValidB), 64'(v[1][0]));
        check("ch1vB",  64'(ch1ValidB), 64'(v[1][1]));
        check("ch0dB",  64'(ch0DataB),  64'(mHeld[1][0]));
        check("ch1dB",  64'(ch1DataB),  64'(mHeld[1][1]));
    endtask

    // Advance one clock, let the model follow, then sample 1 time unit after the edge.
    task automatic applyStimulus();
        @(posedge clk);
        edgeN++;
        if (rst_n) modelEdge();
        #1;
        checkOutput();
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        sync  = 1'b0;
        fw0   = '0;
        fw1   = '0;
        poff0 = '0;
        poff1 = '0;
        amp0  = 8'd255;
        amp1  = 8'd77;
        modelReset();
        repeat (3) applyStimulus();
        rst_n = 1'b1;

        // Ramp: ch0 steps one address per issue, ch1 two.
        en  = 1'b1;
        fw0 = 32'h0040_0000;
        fw1 = 32'h0080_0000;
        repeat (40) applyStimulus();

        // Pause with reads in flight, then resume.
        en = 1'b0;
        repeat (5) applyStimulus();
        en = 1'b1;
        repeat (10) applyStimulus();

        // Phase reset while reads are in flight, also while paused.
        sync = 1'b1;
        applyStimulus();
        sync = 1'b0;
        repeat (10) applyStimulus();
        en   = 1'b0;
        sync = 1'b1;
        applyStimulus();
        sync = 1'b0;
        applyStimulus();
        en = 1'b1;
        repeat (6) applyStimulus();

        // Offset 1023 on ch0: address wraps and comes back after 1024 issues.
        sync  = 1'b1;
        applyStimulus();
        sync  = 1'b0;
        poff0 = 10'd1023;
        repeat (2060) applyStimulus();

        // Randomised words, offsets, enable and sync.
        repeat (400) begin
            fw0   = $urandom;
            fw1   = $urandom;
            poff0 = AW'($urandom);
            poff1 = AW'($urandom);
            en    = ($urandom_range(0, 9) != 0);
            sync  = ($urandom_range(0, 19) == 0);
            applyStimulus();
        end
        sync = 1'b0;

        // Asynchronous reset in the middle of a cycle.
        en = 1'b1;
        repeat (7) applyStimulus();
        #3;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput();
        repeat (2) applyStimulus();
        rst_n = 1'b1;
        poff0 = 10'd5;
        fw0   = 32'h0040_0000;
        repeat (20) applyStimulus();

        // Zero frequency: constant address, strobes continue.
        fw0 = '0;
        fw1 = '0;
        repeat (12) applyStimulus();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
